// File: rtl/player_hand_if.sv
// Deck draw handshake between a player hand (master, requester) and the shared deck (slave).
//   deck_draw  : one-hot draw request (001/010/100), held while cards are being collected
//   deck_drawn : one-cycle strobe from the deck, one card delivered this cycle
//   deck_card  : delivered card {color[1:0], value[3:0]}, valid with deck_drawn
interface player_hand_if;
  logic [2:0] deck_draw;
  logic       deck_drawn;
  logic [5:0] deck_card;

  modport master (
    output deck_draw,
    input  deck_drawn,
    input  deck_card
  );

  modport slave (
    input  deck_draw,
    output deck_drawn,
    output deck_card
  );
endinterface

// File: rtl/player_hand.sv
// Per-player card store. Turns draw commands into a held request toward the deck, captures
// delivered cards into a gap-free array, checks play legality against the discard top card
// and removes played cards by moving the last card into the vacated slot.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_clear                 empty the hand, abort any draw
//   i_req_draw              one-hot draw command (1/2/4 cards), sampled in idle
//   deck                    deck draw handshake (master side)
//   i_play, i_play_idx      play request and slot, sampled in idle
//   i_top_card              discard pile top card
//   o_play_valid/_reject    one-cycle play outcome pulses; o_play_card is the removed card
//   o_draw_done             one-cycle pulse when a draw command completes
//   o_busy                  not idle
//   o_count                 cards held
//   o_overflow              sticky: a delivered card was dropped on a full hand
//   i_rd_idx, o_rd_card     combinational display read port (0 beyond count)
module player_hand #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic [2:0]    i_req_draw,
  player_hand_if.master deck,
  input  logic          i_play,
  input  logic [IW-1:0] i_play_idx,
  input  logic [5:0]    i_top_card,
  output logic          o_play_valid,
  output logic          o_play_reject,
  output logic [5:0]    o_play_card,
  output logic          o_draw_done,
  output logic          o_busy,
  output logic [IW:0]   o_count,
  output logic          o_overflow,
  input  logic [IW-1:0] i_rd_idx,
  output logic [5:0]    o_rd_card
);

  typedef enum logic [1:0] {StIdle, StCollect, StPlay, StDone} state_e;

  localparam logic [IW:0] Full = (IW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];
  logic [IW:0]   count_q, count_d;
  logic [2:0]    remaining_q, remaining_d;
  logic [2:0]    deck_draw_q, deck_draw_d;
  logic [IW-1:0] play_idx_q, play_idx_d;
  logic          overflow_q, overflow_d;
  logic          play_valid_q, play_valid_d;
  logic          play_reject_q, play_reject_d;
  logic [5:0]    play_card_q, play_card_d;
  logic          draw_done_q, draw_done_d;

  logic [5:0]    sel_card;
  logic          sel_legal;
  logic          req_onehot;
  logic [IW-1:0] last_idx;

  assign sel_card   = mem_q[play_idx_q];
  // Wild (13) and wild draw four (14) match anything; otherwise color or value must match.
  assign sel_legal  = (sel_card[3:0] == 4'd13) || (sel_card[3:0] == 4'd14) ||
                      (sel_card[5:4] == i_top_card[5:4]) || (sel_card[3:0] == i_top_card[3:0]);
  assign req_onehot = (i_req_draw == 3'b001) || (i_req_draw == 3'b010) ||
                      (i_req_draw == 3'b100);
  assign last_idx   = IW'(count_q - 1'b1);

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    count_d       = count_q;
    remaining_d   = remaining_q;
    deck_draw_d   = deck_draw_q;
    play_idx_d    = play_idx_q;
    overflow_d    = overflow_q;
    play_valid_d  = 1'b0;
    play_reject_d = 1'b0;
    play_card_d   = play_card_q;
    draw_done_d   = 1'b0;

    if (i_clear) begin
      state_d     = StIdle;
      count_d     = '0;
      remaining_d = '0;
      deck_draw_d = '0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_onehot) begin
            deck_draw_d = i_req_draw;
            remaining_d = (i_req_draw == 3'b001) ? 3'd1 :
                          (i_req_draw == 3'b010) ? 3'd2 : 3'd4;
            state_d     = StCollect;
          end else if (i_play) begin
            play_idx_d = i_play_idx;
            state_d    = StPlay;
          end
        end
        StCollect: begin
          if (deck.deck_drawn) begin
            if (count_q < Full) begin
              mem_d[count_q[IW-1:0]] = deck.deck_card;
              count_d                = count_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            remaining_d = remaining_q - 1'b1;
            // Drop the request on the edge sampling the last strobe.
            if (remaining_q == 3'd1) begin
              deck_draw_d = '0;
              state_d     = StDone;
            end
          end
        end
        StPlay: begin
          if (sel_legal && ({1'b0, play_idx_q} < count_q)) begin
            play_valid_d      = 1'b1;
            play_card_d       = sel_card;
            // Fill the hole with the last card to keep the array gap-free.
            mem_d[play_idx_q] = mem_q[last_idx];
            count_d           = count_q - 1'b1;
          end else begin
            play_reject_d = 1'b1;
          end
          state_d = StIdle;
        end
        StDone: begin
          draw_done_d = 1'b1;
          state_d     = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q       <= '0;
      remaining_q   <= '0;
      deck_draw_q   <= '0;
      play_idx_q    <= '0;
      overflow_q    <= 1'b0;
      play_valid_q  <= 1'b0;
      play_reject_q <= 1'b0;
      play_card_q   <= '0;
      draw_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      count_q       <= count_d;
      remaining_q   <= remaining_d;
      deck_draw_q   <= deck_draw_d;
      play_idx_q    <= play_idx_d;
      overflow_q    <= overflow_d;
      play_valid_q  <= play_valid_d;
      play_reject_q <= play_reject_d;
      play_card_q   <= play_card_d;
      draw_done_q   <= draw_done_d;
    end
  end

  assign deck.deck_draw = deck_draw_q;
  assign o_play_valid   = play_valid_q;
  assign o_play_reject  = play_reject_q;
  assign o_play_card    = play_card_q;
  assign o_draw_done    = draw_done_q;
  assign o_busy         = (state_q != StIdle);
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_rd_card      = ({1'b0, i_rd_idx} < count_q) ? mem_q[i_rd_idx] : 6'h00;

endmodule

// File: tb/tb_player_hand.sv
// Scoreboard bench for player_hand (DEPTH=8): expected play outcomes and draw completions are
// queued when stimulus is driven and checked when the DUT pulses its outputs.
module tb_player_hand;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] req_draw = '0;
  logic       play = 1'b0;
  logic [2:0] play_idx = '0;
  logic [5:0] top_card = '0;
  logic [2:0] rd_idx = '0;
  logic       play_valid, play_reject, draw_done, busy, overflow;
  logic [5:0] play_card, rd_card;
  logic [3:0] count;

  player_hand_if deck_if ();

  player_hand #(.DEPTH(Depth)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clear      (clear),
    .i_req_draw   (req_draw),
    .deck         (deck_if),
    .i_play       (play),
    .i_play_idx   (play_idx),
    .i_top_card   (top_card),
    .o_play_valid (play_valid),
    .o_play_reject(play_reject),
    .o_play_card  (play_card),
    .o_draw_done  (draw_done),
    .o_busy       (busy),
    .o_count      (count),
    .o_overflow   (overflow),
    .i_rd_idx     (rd_idx),
    .o_rd_card    (rd_card)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] play_q [$];  // {valid, reject, card}
  logic [3:0] done_q [$];  // count expected at the done pulse
  logic [5:0] hand [$];    // reference hand contents
  logic       model_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] c, input logic [5:0] top);
    return (c[3:0] == 4'd13) || (c[3:0] == 4'd14) || (c[5:4] == top[5:4]) ||
           (c[3:0] == top[3:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (play_valid || play_reject) begin
        if (play_q.size() == 0) begin
          check("unexpected_play", {30'd0, play_valid, play_reject}, 32'd0);
        end else begin
          logic [7:0] e;
          e = play_q.pop_front();
          check("play_result", {24'd0, play_valid, play_reject, play_valid ? play_card : 6'h00},
                {24'd0, e});
        end
      end
      if (draw_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", {31'd0, draw_done}, 32'd0);
        end else begin
          logic [3:0] e;
          e = done_q.pop_front();
          check("draw_done_count", {28'd0, count}, {28'd0, e});
        end
      end
    end
  end

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    hand.delete();
    model_ovf = 1'b0;
  endtask

  // Cards are taken from the low end of 'cards', six bits each; 'gap' idle cycles per strobe.
  task automatic do_draw(input logic [2:0] code, input logic [23:0] cards, input int gap);
    int n;
    n = (code == 3'b001) ? 1 : (code == 3'b010) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      if (hand.size() < Depth) hand.push_back(cards[i*6 +: 6]);
      else model_ovf = 1'b1;
    end
    done_q.push_back(4'(hand.size()));
    req_draw = code;
    step();
    req_draw = '0;
    check("deck_draw_on", {29'd0, deck_if.deck_draw}, {29'd0, code});
    for (int i = 0; i < n; i++) begin
      repeat (gap) step();
      deck_if.deck_drawn = 1'b1;
      deck_if.deck_card  = cards[i*6 +: 6];
      step();
      deck_if.deck_drawn = 1'b0;
    end
    check("deck_draw_off", {29'd0, deck_if.deck_draw}, 32'd0);
    repeat (3) step();
  endtask

  task automatic do_play(input logic [2:0] idx, input logic [5:0] top);
    logic ok;
    top_card = top;
    ok = 1'b0;
    if (int'(idx) < hand.size()) ok = legal(hand[idx], top);
    if (ok) begin
      play_q.push_back({2'b10, hand[idx]});
      hand[idx] = hand[hand.size()-1];
      void'(hand.pop_back());
    end else begin
      play_q.push_back({2'b01, 6'h00});
    end
    play     = 1'b1;
    play_idx = idx;
    step();
    play = 1'b0;
    step();
  endtask

  task automatic check_slot(input string tag, input logic [2:0] idx, input logic [5:0] exp);
    rd_idx = idx;
    #1;
    check(tag, {26'd0, rd_card}, {26'd0, exp});
  endtask

  task automatic check_hand();
    check("count_model", {28'd0, count}, hand.size());
    check("overflow_model", {31'd0, overflow}, {31'd0, model_ovf});
    for (int i = 0; i < Depth; i++) begin
      rd_idx = 3'(i);
      #1;
      check("rd_card_model", {26'd0, rd_card}, (i < hand.size()) ? {26'd0, hand[i]} : 32'd0);
    end
  endtask

  initial begin
    deck_if.deck_drawn = 1'b0;
    deck_if.deck_card  = '0;
    #12;
    check("rst_deck_draw", {29'd0, deck_if.deck_draw}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_pulses", {29'd0, play_valid, play_reject, draw_done}, 32'd0);
    check("rst_play_card", {26'd0, play_card}, 32'd0);
    rst_n = 1'b1;
    step();

    // Four-card draw with idle cycles between strobes.
    do_draw(3'b100, {6'h3E, 6'h2D, 6'h12, 6'h01}, 1);
    check("draw4_count", {28'd0, count}, 32'd4);
    check_slot("draw4_slot0", 3'd0, 6'h01);
    check_slot("draw4_slot1", 3'd1, 6'h12);
    check_slot("draw4_slot2", 3'd2, 6'h2D);
    check_slot("draw4_slot3", 3'd3, 6'h3E);
    check_slot("draw4_slot4", 3'd4, 6'h00);
    check_hand();

    // Play sequence against blue 5.
    do_clear();
    do_draw(3'b010, {6'h00, 6'h00, 6'h17, 6'h05}, 0);
    do_draw(3'b001, {6'h00, 6'h00, 6'h00, 6'h2D}, 2);
    do_play(3'd0, 6'h35);
    check_slot("play_slot0_moved", 3'd0, 6'h2D);
    check("play_count2", {28'd0, count}, 32'd2);
    do_play(3'd3, 6'h35);
    check("bad_idx_count", {28'd0, count}, 32'd2);
    check_slot("bad_idx_slot0", 3'd0, 6'h2D);
    do_play(3'd0, 6'h35);
    do_play(3'd0, 6'h35);
    check("illegal_count", {28'd0, count}, 32'd1);
    check_slot("illegal_slot0", 3'd0, 6'h17);
    check_hand();

    // Overflow: 7 cards held, draw two.
    do_clear();
    do_draw(3'b100, {6'h24, 6'h23, 6'h22, 6'h21}, 0);
    do_draw(3'b010, {6'h00, 6'h00, 6'h26, 6'h25}, 1);
    do_draw(3'b001, {6'h00, 6'h00, 6'h00, 6'h27}, 0);
    do_draw(3'b010, {6'h00, 6'h00, 6'h0B, 6'h0A}, 1);
    check("ovf_count", {28'd0, count}, 32'd8);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check_slot("ovf_slot7", 3'd7, 6'h0A);
    check_hand();

    // Clear after the first of four strobes.
    do_clear();
    check("clear_ovf", {31'd0, overflow}, 32'd0);
    req_draw = 3'b100;
    step();
    req_draw = '0;
    deck_if.deck_drawn = 1'b1;
    deck_if.deck_card  = 6'h31;
    step();
    deck_if.deck_drawn = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("abort_count", {28'd0, count}, 32'd0);
    check("abort_deck_draw", {29'd0, deck_if.deck_draw}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      deck_if.deck_drawn = 1'b1;
      deck_if.deck_card  = 6'h32;
      step();
      deck_if.deck_drawn = 1'b0;
    end
    repeat (3) step();
    check("abort_late_strobes", {28'd0, count}, 32'd0);

    // Commands while busy are ignored; draw beats play in idle.
    req_draw = 3'b001;
    step();
    req_draw = 3'b011;
    play     = 1'b1;
    play_idx = 3'd0;
    step();
    req_draw = '0;
    play     = 1'b0;
    check("busy_collect", {31'd0, busy}, 32'd1);
    check("busy_deck_draw", {29'd0, deck_if.deck_draw}, 32'd1);
    hand.push_back(6'h33);
    done_q.push_back(4'd1);
    deck_if.deck_drawn = 1'b1;
    deck_if.deck_card  = 6'h33;
    step();
    deck_if.deck_drawn = 1'b0;
    check("busy_deck_off", {29'd0, deck_if.deck_draw}, 32'd0);
    repeat (3) step();
    req_draw = 3'b011;
    step();
    req_draw = '0;
    check("nonhot_busy", {31'd0, busy}, 32'd0);
    check("nonhot_deck_draw", {29'd0, deck_if.deck_draw}, 32'd0);
    req_draw = 3'b001;
    play     = 1'b1;
    play_idx = 3'd0;
    top_card = 6'h33;
    step();
    req_draw = '0;
    play     = 1'b0;
    check("draw_wins", {29'd0, deck_if.deck_draw}, 32'd1);
    hand.push_back(6'h14);
    done_q.push_back(4'd2);
    deck_if.deck_drawn = 1'b1;
    deck_if.deck_card  = 6'h14;
    step();
    deck_if.deck_drawn = 1'b0;
    repeat (3) step();
    check_hand();

    // Asynchronous reset while collecting.
    req_draw = 3'b100;
    step();
    req_draw = '0;
    check("pre_rst_deck_draw", {29'd0, deck_if.deck_draw}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_deck_draw", {29'd0, deck_if.deck_draw}, 32'd0);
    check("async_rst_count", {28'd0, count}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    hand.delete();
    model_ovf = 1'b0;
    repeat (3) step();

    check("play_q_empty", play_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
